// File: rtl/sat_bin_pkg.sv
// Shared encodings, FSM state codes and field packing helpers for the sat_bin solver.
// Variable-state word is {value[1:0], implied, level[15:0]}; level-state word is {dcd_bin[9:0], has_bkt}.
package sat_bin_pkg;

  localparam int unsigned VS_LVL_W = 16;
  localparam int unsigned LS_BIN_W = 10;

  localparam logic [1:0] VAL_UNASSIGNED = 2'b00;
  localparam logic [1:0] VAL_FALSE      = 2'b01;
  localparam logic [1:0] VAL_TRUE       = 2'b10;

  localparam logic [1:0] LIT_ABSENT = 2'b00;
  localparam logic [1:0] LIT_NEG    = 2'b01;
  localparam logic [1:0] LIT_POS    = 2'b10;
  localparam logic [1:0] LIT_BOTH   = 2'b11;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_INIT    = 4'd1;
  localparam logic [3:0] ST_DECIDE  = 4'd2;
  localparam logic [3:0] ST_SCAN_CL = 4'd3;
  localparam logic [3:0] ST_LIT_V   = 4'd4;
  localparam logic [3:0] ST_LIT_S   = 4'd5;
  localparam logic [3:0] ST_BKT_RD  = 4'd6;
  localparam logic [3:0] ST_BKT_EV  = 4'd7;
  localparam logic [3:0] ST_DONE    = 4'd8;

  function automatic logic [VS_LVL_W+2:0] pack_vs(input logic [1:0] value, input logic implied,
                                                  input logic [VS_LVL_W-1:0] lvl);
    return {value, implied, lvl};
  endfunction

  function automatic logic [LS_BIN_W:0] pack_ls(input logic [LS_BIN_W-1:0] dcd_bin, input logic has_bkt);
    return {dcd_bin, has_bkt};
  endfunction

  function automatic logic [1:0] vs_value(input logic [VS_LVL_W+2:0] vs);
    return vs[VS_LVL_W+2:VS_LVL_W+1];
  endfunction

  function automatic logic lit_present(input logic [1:0] lit);
    return (lit == LIT_POS) || (lit == LIT_NEG);
  endfunction

  // A literal is false only once its variable holds the opposing value.
  function automatic logic lit_false(input logic [1:0] lit, input logic [1:0] value);
    return ((lit == LIT_POS) && (value == VAL_FALSE)) || ((lit == LIT_NEG) && (value == VAL_TRUE));
  endfunction

endpackage

// File: rtl/sat_bin_ram.sv
// Simple dual-port RAM: one write port, one read port, 1-cycle read latency, write-first on collision.
// No flow control; a write lands on the edge where we is high.
module sat_bin_ram #(
  parameter int unsigned W     = 8,
  parameter int unsigned AW    = 9,
  parameter int unsigned DEPTH = 1 << AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (we && (waddr == raddr)) rdata <= wdata;
    else                        rdata <= mem[raddr];
  end

endmodule

// File: rtl/sat_bin.sv
// Chronological-backtracking DPLL solver over four on-chip RAMs loaded through external write ports.
// Latency is data dependent; apply_ex_i takes the RAMs and aborts any solve in progress.
module sat_bin
  import sat_bin_pkg::*;
#(
  parameter int unsigned NUM_CLAUSES_A_BIN     = 8,
  parameter int unsigned NUM_VARS_A_BIN        = 8,
  parameter int unsigned NUM_LVLS_A_BIN        = 8,
  parameter int unsigned WIDTH_BIN_ID          = 10,
  parameter int unsigned WIDTH_CLAUSES         = NUM_VARS_A_BIN * 2,
  parameter int unsigned WIDTH_VAR             = 12,
  parameter int unsigned WIDTH_LVL             = 16,
  parameter int unsigned WIDTH_VAR_STATES      = 19,
  parameter int unsigned WIDTH_LVL_STATES      = 11,
  parameter int unsigned ADDR_WIDTH_CLAUSES    = 9,
  parameter int unsigned ADDR_WIDTH_VAR        = 9,
  parameter int unsigned ADDR_WIDTH_VAR_STATES = 9,
  parameter int unsigned ADDR_WIDTH_LVL_STATES = 9
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_i,
  output logic                             done_o,
  output logic                             global_sat_o,
  output logic                             global_unsat_o,
  input  logic                             bin_info_en,
  input  logic [WIDTH_VAR-1:0]             nv_all_i,
  input  logic [WIDTH_CLAUSES-1:0]         nb_all_i,
  input  logic                             apply_ex_i,
  input  logic                             ram_we_v_ex_i,
  input  logic [WIDTH_VAR-1:0]             ram_din_v_ex_i,
  input  logic [ADDR_WIDTH_VAR-1:0]        ram_addr_v_ex_i,
  input  logic                             ram_we_c_ex_i,
  input  logic [WIDTH_CLAUSES-1:0]         ram_din_c_ex_i,
  input  logic [ADDR_WIDTH_CLAUSES-1:0]    ram_addr_c_ex_i,
  input  logic                             ram_we_vs_ex_i,
  input  logic [WIDTH_VAR_STATES-1:0]      ram_din_vs_ex_i,
  input  logic [ADDR_WIDTH_VAR_STATES-1:0] ram_addr_vs_ex_i,
  input  logic                             ram_we_ls_ex_i,
  input  logic [WIDTH_LVL_STATES-1:0]      ram_din_ls_ex_i,
  input  logic [ADDR_WIDTH_LVL_STATES-1:0] ram_addr_ls_ex_i
);

  localparam int unsigned CW = WIDTH_CLAUSES + $clog2(NUM_CLAUSES_A_BIN) + 1;
  localparam int unsigned JW = $clog2(NUM_VARS_A_BIN) + 1;
  localparam int unsigned SW = $clog2(NUM_CLAUSES_A_BIN);

  if (WIDTH_VAR_STATES != VS_LVL_W + 3 || WIDTH_LVL != VS_LVL_W || WIDTH_LVL_STATES != LS_BIN_W + 1 ||
      WIDTH_BIN_ID != LS_BIN_W || NUM_LVLS_A_BIN < 1) begin : g_bad_params
    $error("sat_bin: unsupported parameter set");
  end

  logic [3:0]                  state;
  logic [WIDTH_LVL-1:0]        lvl;
  logic [WIDTH_VAR-1:0]        nv_q;
  logic [WIDTH_CLAUSES-1:0]    nb_q;
  logic [WIDTH_VAR:0]          init_idx;
  logic [CW-1:0]               cidx, cidx_d;
  logic [SW-1:0]               slot;
  logic [ADDR_WIDTH_VAR-1:0]   var_base;
  logic [WIDTH_CLAUSES-1:0]    clause_q;
  logic [JW-1:0]               j;
  logic                        has_lit, all_false, pend_vld;
  logic [1:0]                  pend_lit;

  logic [WIDTH_CLAUSES-1:0]         c_rdata;
  logic [WIDTH_VAR-1:0]             var_rdata;
  logic [WIDTH_VAR_STATES-1:0]      vs_rdata;
  logic [WIDTH_LVL_STATES-1:0]      ls_rdata;
  logic [ADDR_WIDTH_VAR-1:0]        v_raddr;
  logic [ADDR_WIDTH_VAR_STATES-1:0] vs_raddr;

  logic                             vs_we_e, ls_we_e;
  logic [ADDR_WIDTH_VAR_STATES-1:0] vs_waddr_e;
  logic [WIDTH_VAR_STATES-1:0]      vs_wdata_e;
  logic [ADDR_WIDTH_LVL_STATES-1:0] ls_waddr_e;
  logic [WIDTH_LVL_STATES-1:0]      ls_wdata_e;

  logic [1:0]           lit_j;
  logic                 j_end, pend_false, eff_has_lit, eff_all_false, conflict;
  logic                 busy, in_scan;
  logic [WIDTH_LVL-1:0] lvl_nv, lvl_inc;
  logic [CW-1:0]        total_cl;
  logic                 unused_rd;

  assign lit_j         = clause_q[{j[JW-2:0], 1'b0} +: 2];
  assign j_end         = (j == JW'(NUM_VARS_A_BIN));
  // The vs read issued in LIT_S is resolved in the following LIT_V cycle.
  assign pend_false    = lit_false(pend_lit, vs_value(vs_rdata));
  assign eff_has_lit   = has_lit | pend_vld;
  assign eff_all_false = all_false & (~pend_vld | pend_false);
  assign conflict      = eff_has_lit & eff_all_false;
  assign lvl_nv        = WIDTH_LVL'(nv_q);
  assign lvl_inc       = lvl + WIDTH_LVL'(1);
  assign total_cl      = CW'(nb_q) * CW'(NUM_CLAUSES_A_BIN);
  assign busy          = (state != ST_IDLE) && (state != ST_DONE);
  assign in_scan       = (state == ST_SCAN_CL) || (state == ST_LIT_V) || (state == ST_LIT_S);
  assign unused_rd     = ^{vs_rdata[WIDTH_LVL:0], ls_rdata[WIDTH_LVL_STATES-1:1]};

  always_comb begin
    cidx_d     = cidx;
    vs_we_e    = 1'b0;
    vs_waddr_e = '0;
    vs_wdata_e = '0;
    ls_we_e    = 1'b0;
    ls_waddr_e = '0;
    ls_wdata_e = '0;
    v_raddr    = var_base + ADDR_WIDTH_VAR'(j);
    vs_raddr   = var_rdata[ADDR_WIDTH_VAR_STATES-1:0];
    case (state)
      ST_INIT: begin
        if (init_idx <= {1'b0, nv_q}) begin
          vs_we_e    = 1'b1;
          vs_waddr_e = init_idx[ADDR_WIDTH_VAR_STATES-1:0];
          ls_we_e    = 1'b1;
          ls_waddr_e = init_idx[ADDR_WIDTH_LVL_STATES-1:0];
        end
      end
      ST_DECIDE: begin
        if (lvl != lvl_nv) begin
          vs_we_e    = 1'b1;
          vs_waddr_e = lvl_inc[ADDR_WIDTH_VAR_STATES-1:0];
          vs_wdata_e = pack_vs(VAL_FALSE, 1'b0, lvl_inc);
          ls_we_e    = 1'b1;
          ls_waddr_e = lvl_inc[ADDR_WIDTH_LVL_STATES-1:0];
          ls_wdata_e = pack_ls('0, 1'b0);
          cidx_d     = CW'(1);
        end
      end
      ST_LIT_V: begin
        if (j_end && !conflict) cidx_d = cidx + CW'(1);
      end
      ST_BKT_EV: begin
        vs_we_e    = 1'b1;
        vs_waddr_e = lvl[ADDR_WIDTH_VAR_STATES-1:0];
        if (!ls_rdata[0]) begin
          vs_wdata_e = pack_vs(VAL_TRUE, 1'b1, lvl);
          ls_we_e    = 1'b1;
          ls_waddr_e = lvl[ADDR_WIDTH_LVL_STATES-1:0];
          ls_wdata_e = pack_ls('0, 1'b1);
          cidx_d     = CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      lvl            <= '0;
      nv_q           <= '0;
      nb_q           <= '0;
      init_idx       <= '0;
      cidx           <= '0;
      slot           <= '0;
      var_base       <= '0;
      clause_q       <= '0;
      j              <= '0;
      has_lit        <= 1'b0;
      all_false      <= 1'b0;
      pend_vld       <= 1'b0;
      pend_lit       <= LIT_ABSENT;
      done_o         <= 1'b0;
      global_sat_o   <= 1'b0;
      global_unsat_o <= 1'b0;
    end else begin
      if (bin_info_en && !in_scan) begin
        nv_q <= nv_all_i;
        nb_q <= nb_all_i;
      end
      cidx <= cidx_d;
      if (apply_ex_i && busy) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start_i && !apply_ex_i) begin
              state          <= ST_INIT;
              init_idx       <= (WIDTH_VAR+1)'(1);
              lvl            <= '0;
              done_o         <= 1'b0;
              global_sat_o   <= 1'b0;
              global_unsat_o <= 1'b0;
            end
          end
          ST_INIT: begin
            if (init_idx <= {1'b0, nv_q}) init_idx <= init_idx + (WIDTH_VAR+1)'(1);
            else                          state    <= ST_DECIDE;
          end
          ST_DECIDE: begin
            if (lvl == lvl_nv) begin
              state        <= ST_DONE;
              done_o       <= 1'b1;
              global_sat_o <= 1'b1;
            end else begin
              lvl      <= lvl_inc;
              slot     <= '0;
              var_base <= ADDR_WIDTH_VAR'(1);
              state    <= ST_SCAN_CL;
            end
          end
          ST_SCAN_CL: begin
            if (cidx > total_cl) begin
              state <= ST_DECIDE;
            end else begin
              clause_q  <= c_rdata;
              j         <= '0;
              has_lit   <= 1'b0;
              all_false <= 1'b1;
              pend_vld  <= 1'b0;
              state     <= ST_LIT_V;
            end
          end
          ST_LIT_V: begin
            has_lit   <= eff_has_lit;
            all_false <= eff_all_false;
            pend_vld  <= 1'b0;
            if (j_end) begin
              if (conflict) begin
                state <= ST_BKT_RD;
              end else begin
                state <= ST_SCAN_CL;
                if (slot == SW'(NUM_CLAUSES_A_BIN - 1)) begin
                  slot     <= '0;
                  var_base <= var_base + ADDR_WIDTH_VAR'(NUM_VARS_A_BIN);
                end else begin
                  slot <= slot + SW'(1);
                end
              end
            end else if (lit_present(lit_j)) begin
              state <= ST_LIT_S;
            end else begin
              j <= j + JW'(1);
            end
          end
          ST_LIT_S: begin
            // A zero global id marks an unused local slot, so the literal is dropped.
            pend_vld <= |var_rdata;
            pend_lit <= lit_j;
            j        <= j + JW'(1);
            state    <= ST_LIT_V;
          end
          ST_BKT_RD: state <= ST_BKT_EV;
          ST_BKT_EV: begin
            if (!ls_rdata[0]) begin
              slot     <= '0;
              var_base <= ADDR_WIDTH_VAR'(1);
              state    <= ST_SCAN_CL;
            end else begin
              lvl <= lvl - WIDTH_LVL'(1);
              if (lvl == WIDTH_LVL'(1)) begin
                state          <= ST_DONE;
                done_o         <= 1'b1;
                global_unsat_o <= 1'b1;
              end else begin
                state <= ST_BKT_RD;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  sat_bin_ram #(.W(WIDTH_CLAUSES), .AW(ADDR_WIDTH_CLAUSES)) u_ram_c (
    .clk   (clk),
    .we    (apply_ex_i & ram_we_c_ex_i),
    .waddr (ram_addr_c_ex_i),
    .wdata (ram_din_c_ex_i),
    .raddr (cidx_d[ADDR_WIDTH_CLAUSES-1:0]),
    .rdata (c_rdata)
  );

  sat_bin_ram #(.W(WIDTH_VAR), .AW(ADDR_WIDTH_VAR)) u_ram_v (
    .clk   (clk),
    .we    (apply_ex_i & ram_we_v_ex_i),
    .waddr (ram_addr_v_ex_i),
    .wdata (ram_din_v_ex_i),
    .raddr (v_raddr),
    .rdata (var_rdata)
  );

  sat_bin_ram #(.W(WIDTH_VAR_STATES), .AW(ADDR_WIDTH_VAR_STATES)) u_ram_vs (
    .clk   (clk),
    .we    (apply_ex_i ? ram_we_vs_ex_i : vs_we_e),
    .waddr (apply_ex_i ? ram_addr_vs_ex_i : vs_waddr_e),
    .wdata (apply_ex_i ? ram_din_vs_ex_i : vs_wdata_e),
    .raddr (vs_raddr),
    .rdata (vs_rdata)
  );

  sat_bin_ram #(.W(WIDTH_LVL_STATES), .AW(ADDR_WIDTH_LVL_STATES)) u_ram_ls (
    .clk   (clk),
    .we    (apply_ex_i ? ram_we_ls_ex_i : ls_we_e),
    .waddr (apply_ex_i ? ram_addr_ls_ex_i : ls_waddr_e),
    .wdata (apply_ex_i ? ram_din_ls_ex_i : ls_wdata_e),
    .raddr (lvl[ADDR_WIDTH_LVL_STATES-1:0]),
    .rdata (ls_rdata)
  );

endmodule

// File: tb/tb_sat_bin.sv
// Directed bench for sat_bin: small SAT/UNSAT problems, empty problem, reset and abort behaviour.
module tb_sat_bin;

  localparam int BUDGET = 5000;
  localparam int R_C = 0;
  localparam int R_V = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        done_o, global_sat_o, global_unsat_o;
  logic        bin_info_en = 1'b0;
  logic [11:0] nv_all_i = '0;
  logic [15:0] nb_all_i = '0;
  logic        apply_ex_i = 1'b0;
  logic        ram_we_v_ex_i = 1'b0;
  logic [11:0] ram_din_v_ex_i = '0;
  logic [8:0]  ram_addr_v_ex_i = '0;
  logic        ram_we_c_ex_i = 1'b0;
  logic [15:0] ram_din_c_ex_i = '0;
  logic [8:0]  ram_addr_c_ex_i = '0;
  logic        ram_we_vs_ex_i = 1'b0;
  logic [18:0] ram_din_vs_ex_i = '0;
  logic [8:0]  ram_addr_vs_ex_i = '0;
  logic        ram_we_ls_ex_i = 1'b0;
  logic [10:0] ram_din_ls_ex_i = '0;
  logic [8:0]  ram_addr_ls_ex_i = '0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sat_bin dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start_i),
    .done_o           (done_o),
    .global_sat_o     (global_sat_o),
    .global_unsat_o   (global_unsat_o),
    .bin_info_en      (bin_info_en),
    .nv_all_i         (nv_all_i),
    .nb_all_i         (nb_all_i),
    .apply_ex_i       (apply_ex_i),
    .ram_we_v_ex_i    (ram_we_v_ex_i),
    .ram_din_v_ex_i   (ram_din_v_ex_i),
    .ram_addr_v_ex_i  (ram_addr_v_ex_i),
    .ram_we_c_ex_i    (ram_we_c_ex_i),
    .ram_din_c_ex_i   (ram_din_c_ex_i),
    .ram_addr_c_ex_i  (ram_addr_c_ex_i),
    .ram_we_vs_ex_i   (ram_we_vs_ex_i),
    .ram_din_vs_ex_i  (ram_din_vs_ex_i),
    .ram_addr_vs_ex_i (ram_addr_vs_ex_i),
    .ram_we_ls_ex_i   (ram_we_ls_ex_i),
    .ram_din_ls_ex_i  (ram_din_ls_ex_i),
    .ram_addr_ls_ex_i (ram_addr_ls_ex_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ext_wr(input int ram, input int addr, input logic [15:0] data);
    if (ram == R_C) begin
      ram_we_c_ex_i = 1'b1; ram_addr_c_ex_i = 9'(addr); ram_din_c_ex_i = data;
    end else begin
      ram_we_v_ex_i = 1'b1; ram_addr_v_ex_i = 9'(addr); ram_din_v_ex_i = data[11:0];
    end
    tick();
    ram_we_c_ex_i = 1'b0;
    ram_we_v_ex_i = 1'b0;
  endtask

  task automatic clear_bins(input int nbins);
    for (int i = 1; i <= nbins * 8; i++) begin
      ext_wr(R_C, i, 16'h0000);
      ext_wr(R_V, i, 16'h0000);
    end
  endtask

  task automatic set_info(input int nv, input int nb);
    bin_info_en = 1'b1; nv_all_i = 12'(nv); nb_all_i = 16'(nb);
    tick();
    bin_info_en = 1'b0;
  endtask

  // nv=2: (x1 | x2), (~x1)
  task automatic load_sat1();
    apply_ex_i = 1'b1;
    clear_bins(1);
    ext_wr(R_V, 1, 16'd1);
    ext_wr(R_V, 2, 16'd2);
    ext_wr(R_C, 1, 16'h000A);
    ext_wr(R_C, 2, 16'h0001);
    apply_ex_i = 1'b0;
    set_info(2, 1);
  endtask

  // nv=1: (x1), (~x1)
  task automatic load_unsat1();
    apply_ex_i = 1'b1;
    clear_bins(1);
    ext_wr(R_V, 1, 16'd1);
    ext_wr(R_C, 1, 16'h0002);
    ext_wr(R_C, 2, 16'h0001);
    apply_ex_i = 1'b0;
    set_info(1, 1);
  endtask

  // nv=3, bin0 local0 -> x1 with (x1); bin1 local0 -> x3 with (~x3)
  task automatic load_two_bin();
    apply_ex_i = 1'b1;
    clear_bins(2);
    ext_wr(R_V, 1, 16'd1);
    ext_wr(R_V, 9, 16'd3);
    ext_wr(R_C, 1, 16'h0002);
    ext_wr(R_C, 9, 16'h0001);
    apply_ex_i = 1'b0;
    set_info(3, 2);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done_o !== 1'b1 && cyc < BUDGET) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    #1;
    tests_run++; if (done_o !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done_o); end
    tests_run++; if (global_sat_o !== 1'b0) begin tests_failed++; $display("FAIL reset_sat: got %b want 0", global_sat_o); end
    tests_run++; if (global_unsat_o !== 1'b0) begin tests_failed++; $display("FAIL reset_unsat: got %b want 0", global_unsat_o); end
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_sat_1bin();
    int cyc;
    load_sat1();
    pulse_start();
    wait_done(cyc);
    tests_run++; if (done_o !== 1'b1) begin tests_failed++; $display("FAIL sat1_done: got %b want 1 after %0d cycles", done_o, cyc); end
    tests_run++; if (global_sat_o !== 1'b1) begin tests_failed++; $display("FAIL sat1_sat: got %b want 1", global_sat_o); end
    tests_run++; if (global_unsat_o !== 1'b0) begin tests_failed++; $display("FAIL sat1_unsat: got %b want 0", global_unsat_o); end
    tests_run++; if (dut.u_ram_vs.mem[1] !== 19'h20001) begin tests_failed++; $display("FAIL sat1_vs1: got %h want 20001", dut.u_ram_vs.mem[1]); end
    tests_run++; if (dut.u_ram_vs.mem[2] !== 19'h50002) begin tests_failed++; $display("FAIL sat1_vs2: got %h want 50002", dut.u_ram_vs.mem[2]); end
  endtask

  task automatic test_unsat_1bin();
    int cyc;
    load_unsat1();
    pulse_start();
    wait_done(cyc);
    tests_run++; if (done_o !== 1'b1) begin tests_failed++; $display("FAIL unsat1_done: got %b want 1 after %0d cycles", done_o, cyc); end
    tests_run++; if (global_unsat_o !== 1'b1) begin tests_failed++; $display("FAIL unsat1_unsat: got %b want 1", global_unsat_o); end
    tests_run++; if (global_sat_o !== 1'b0) begin tests_failed++; $display("FAIL unsat1_sat: got %b want 0", global_sat_o); end
    tests_run++; if (dut.u_ram_vs.mem[1] !== 19'h00000) begin tests_failed++; $display("FAIL unsat1_vs1: got %h want 00000", dut.u_ram_vs.mem[1]); end
  endtask

  task automatic test_two_bin();
    int cyc;
    load_two_bin();
    pulse_start();
    wait_done(cyc);
    tests_run++; if (done_o !== 1'b1) begin tests_failed++; $display("FAIL twobin_done: got %b want 1 after %0d cycles", done_o, cyc); end
    tests_run++; if (global_sat_o !== 1'b1 || global_unsat_o !== 1'b0) begin tests_failed++; $display("FAIL twobin_result: got sat=%b unsat=%b want sat=1 unsat=0", global_sat_o, global_unsat_o); end
    tests_run++; if (dut.u_ram_vs.mem[3] !== 19'h20003) begin tests_failed++; $display("FAIL twobin_vs3: got %h want 20003", dut.u_ram_vs.mem[3]); end
    tests_run++; if (dut.u_ram_vs.mem[1] !== 19'h50001) begin tests_failed++; $display("FAIL twobin_vs1: got %h want 50001", dut.u_ram_vs.mem[1]); end
    tests_run++; if (dut.u_ram_vs.mem[2] !== 19'h20002) begin tests_failed++; $display("FAIL twobin_vs2: got %h want 20002", dut.u_ram_vs.mem[2]); end
  endtask

  task automatic test_empty();
    int cyc;
    set_info(0, 0);
    pulse_start();
    cyc = 0;
    while (done_o !== 1'b1 && cyc < 10) begin
      tick();
      cyc++;
    end
    tests_run++; if (done_o !== 1'b1) begin tests_failed++; $display("FAIL empty_done: got %b want 1 within 10 cycles", done_o); end
    tests_run++; if (global_sat_o !== 1'b1) begin tests_failed++; $display("FAIL empty_sat: got %b want 1", global_sat_o); end
    tests_run++; if (global_unsat_o !== 1'b0) begin tests_failed++; $display("FAIL empty_unsat: got %b want 0", global_unsat_o); end
  endtask

  task automatic test_reset_mid_scan();
    int cyc;
    load_two_bin();
    pulse_start();
    repeat (30) tick();
    #3 rst = 1'b0;
    #1;
    tests_run++; if ({done_o, global_sat_o, global_unsat_o} !== 3'b000) begin tests_failed++; $display("FAIL midrst_outputs: got %b want 000", {done_o, global_sat_o, global_unsat_o}); end
    tick();
    rst = 1'b1;
    repeat (20) tick();
    tests_run++; if (done_o !== 1'b0) begin tests_failed++; $display("FAIL midrst_idle: got done=%b want 0", done_o); end
    set_info(3, 2);
    pulse_start();
    wait_done(cyc);
    tests_run++; if (done_o !== 1'b1) begin tests_failed++; $display("FAIL midrst_done: got %b want 1 after %0d cycles", done_o, cyc); end
    tests_run++; if (global_sat_o !== 1'b1 || global_unsat_o !== 1'b0) begin tests_failed++; $display("FAIL midrst_result: got sat=%b unsat=%b want sat=1 unsat=0", global_sat_o, global_unsat_o); end
    tests_run++; if (dut.u_ram_vs.mem[3] !== 19'h20003) begin tests_failed++; $display("FAIL midrst_vs3: got %h want 20003", dut.u_ram_vs.mem[3]); end
    tests_run++; if (dut.u_ram_vs.mem[1] !== 19'h50001) begin tests_failed++; $display("FAIL midrst_vs1: got %h want 50001", dut.u_ram_vs.mem[1]); end
  endtask

  task automatic test_abort();
    pulse_start();
    repeat (30) tick();
    apply_ex_i = 1'b1;
    tick();
    apply_ex_i = 1'b0;
    repeat (2000) tick();
    tests_run++; if (done_o !== 1'b0 || global_sat_o !== 1'b0) begin tests_failed++; $display("FAIL abort_no_done: got done=%b sat=%b want 0 0", done_o, global_sat_o); end
    apply_ex_i = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    apply_ex_i = 1'b0;
    repeat (2000) tick();
    tests_run++; if (done_o !== 1'b0) begin tests_failed++; $display("FAIL start_ignored: got done=%b want 0", done_o); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    load_unsat1();
    pulse_start();
    wait_done(cyc);
    tests_run++; if (done_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_first_done: got %b want 1 after %0d cycles", done_o, cyc); end
    tests_run++; if (global_unsat_o !== 1'b1 || global_sat_o !== 1'b0) begin tests_failed++; $display("FAIL b2b_first_result: got sat=%b unsat=%b want sat=0 unsat=1", global_sat_o, global_unsat_o); end
    load_sat1();
    tests_run++; if (done_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_held: got done=%b want 1 while reloading", done_o); end
    pulse_start();
    tests_run++; if (done_o !== 1'b0 || global_unsat_o !== 1'b0) begin tests_failed++; $display("FAIL b2b_clear: got done=%b unsat=%b want 0 0", done_o, global_unsat_o); end
    wait_done(cyc);
    tests_run++; if (done_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_second_done: got %b want 1 after %0d cycles", done_o, cyc); end
    tests_run++; if (global_sat_o !== 1'b1) begin tests_failed++; $display("FAIL b2b_second_sat: got %b want 1", global_sat_o); end
    tests_run++; if (global_unsat_o !== 1'b0) begin tests_failed++; $display("FAIL b2b_second_unsat: got %b want 0", global_unsat_o); end
  endtask

  initial begin
    #2 rst = 1'b0;
    test_reset();
    test_sat_1bin();
    test_unsat_1bin();
    test_two_bin();
    test_empty();
    test_reset_mid_scan();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
